// File: rtl/ct_f_spsram_arb.sv
// Single-port SRAM arbiter: clear sweep, round-robin write/read access.
// Owns the SRAM control pins and returns read data one cycle after grant.
module ct_f_spsram_arb #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = 1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic                    rr_rd;
    logic                    arb_en;
    logic [DATA_WIDTH-1:0]   rd_hold;

    assign init_busy = (state == INIT);

    // A pending init_req wins over both requesters for this cycle.
    assign arb_en = (state == IDLE) & ~init_req;

    // rr_rd=1 means read wins a tie; a lone requester always wins.
    assign rd_gnt = arb_en & rd_req & (rr_rd | ~wr_req);
    assign wr_gnt = arb_en & wr_req & (~rr_rd | ~rd_req);

    // Sweep FSM: walk every address once, then serve requesters.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + CNT_ONE;
                    if (init_cnt == CNT_MAX) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (init_req) begin
                        init_cnt <= '0;
                        state    <= INIT;
                    end
                end
                default: begin
                    state    <= INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    // Round-robin pointer: the side just served yields the next tie.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rr_rd <= 1'b1;
        end else if (rd_gnt) begin
            rr_rd <= 1'b0;
        end else if (wr_gnt) begin
            rr_rd <= 1'b1;
        end
    end

    // Read valid follows the grant by exactly one cycle.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_gnt;
        end
    end

    // Keep the last returned word so rd_data stays stable between reads.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_hold <= '0;
        end else if (rd_vld) begin
            rd_hold <= sram_q;
        end
    end

    assign rd_data = rd_vld ? sram_q : rd_hold;

    // SRAM pin mux: sweep write, granted write, granted read, or parked.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_addr = '0;
        sram_din  = '0;
        unique case (1'b1)
            init_busy: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_addr = init_cnt;
                sram_din  = INIT_VALUE;
            end
            wr_gnt: begin
                sram_cen  = 1'b0;
                sram_gwen = ~|wr_mask;
                sram_wen  = ~wr_mask;
                sram_addr = wr_addr;
                sram_din  = wr_data;
            end
            rd_gnt: begin
                sram_cen  = 1'b0;
                sram_addr = rd_addr;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ct_f_spsram_arb.sv
// Bench for ct_f_spsram_arb: behavioural SRAM, reference memory,
// read scoreboard, vector table and sweep/reset sequences.
module tb_ct_f_spsram_arb;

    localparam int AW = 7;
    localparam int DW = 16;
    localparam int N  = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          init_req, init_busy;
    logic          wr_req, wr_gnt, rd_req, rd_gnt, rd_vld;
    logic [AW-1:0] wr_addr, rd_addr, sram_addr;
    logic [DW-1:0] wr_data, wr_mask, rd_data;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_din, sram_q;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;
    int n;

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] wm;
        logic          rd;
        logic [AW-1:0] ra;
        logic          wg;
        logic          rg;
        logic          cen;
        logic          gwen;
        logic [DW-1:0] wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } vec_t;

    vec_t vec [22];

    always #5 clk = ~clk;

    ct_f_spsram_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .INIT_VALUE(16'h0000)
    ) dut (
        .forever_cpuclk(clk),
        .cpurst_b(rst_n),
        .init_req(init_req),
        .init_busy(init_busy),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .wr_gnt(wr_gnt),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_gnt(rd_gnt),
        .rd_vld(rd_vld),
        .rd_data(rd_data),
        .sram_cen(sram_cen),
        .sram_gwen(sram_gwen),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_din(sram_din),
        .sram_q(sram_q)
    );

    // Behavioural single-port SRAM with per-bit active-low write enables.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                mem[sram_addr] <= (mem[sram_addr] & sram_wen) | (sram_din & ~sram_wen);
            end else begin
                sram_q <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on rd_vld, record grants into the reference model.
    task automatic sb_check();
        if (exp_q.size() > 0) begin
            chk("rd_latency", rd_vld, 1);
            if (rd_vld) chk("rd_data", rd_data, exp_q.pop_front());
        end else begin
            chk("spurious_vld", rd_vld, 0);
        end
        chk("gnt_excl", wr_gnt & rd_gnt, 0);
        if (wr_gnt) ref_mem[wr_addr] = (ref_mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        if (rd_gnt) exp_q.push_back(ref_mem[rd_addr]);
    endtask

    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, input logic r, input logic [AW-1:0] ra,
                        input logic ini);
        @(negedge clk);
        wr_req = w;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        rd_req = r;
        rd_addr = ra;
        init_req = ini;
        #1;
        sb_check();
    endtask

    // Called inside a sample window whose cycle is the first sweep cycle.
    task automatic sweep(input int stop, input logic pulse, output int cnt);
        logic [AW-1:0] na;
        cnt = 0;
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
        while (init_busy && cnt < stop) begin
            na = cnt[AW-1:0];
            chk("sweep", {init_busy, sram_cen, sram_gwen, sram_wen, sram_addr, sram_din,
                          wr_gnt, rd_gnt, rd_vld},
                {1'b1, 1'b0, 1'b0, 16'h0, na, 16'h0, 1'b0, 1'b0, 1'b0});
            cnt++;
            @(negedge clk);
            init_req = pulse && (cnt == 50);
            #1;
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        init_req = 1'b0;
    endtask

    task automatic readback_all();
        for (int i = 0; i < N; i++) begin
            step(0, '0, '0, '0, 1, AW'(i), 0);
            chk("rb_gnt", rd_gnt, 1);
        end
        step(0, '0, '0, '0, 0, '0, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 16'hC0DE ^ 16'(i);
        sram_q = '0;
        init_req = 0; wr_req = 0; rd_req = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;

        vec[0]  = '{1'b1, 7'h05, 16'hA5A5, 16'hFFFF, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'h05, 16'hA5A5};
        vec[1]  = '{1'b1, 7'h05, 16'h1234, 16'h00FF, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00, 7'h05, 16'h1234};
        vec[2]  = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b1, 7'h05, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h05, 16'h0000};
        vec[3]  = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 7'h00, 16'h0000};
        vec[4]  = '{1'b1, 7'h06, 16'hFFFF, 16'h0000, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 7'h06, 16'hFFFF};
        vec[5]  = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b1, 7'h06, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h06, 16'h0000};
        vec[6]  = '{1'b1, 7'h07, 16'h1111, 16'hFFFF, 1'b1, 7'h05, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'h07, 16'h1111};
        vec[7]  = '{1'b1, 7'h08, 16'h2222, 16'hFFFF, 1'b1, 7'h07, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h07, 16'h0000};
        vec[8]  = '{1'b1, 7'h08, 16'h2222, 16'hF0F0, 1'b1, 7'h06, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 7'h08, 16'h2222};
        vec[9]  = '{1'b1, 7'h09, 16'h3333, 16'hFFFF, 1'b1, 7'h08, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h08, 16'h0000};
        vec[10] = '{1'b1, 7'h09, 16'h3333, 16'hFFFF, 1'b1, 7'h08, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'h09, 16'h3333};
        vec[11] = '{1'b1, 7'h0A, 16'h4444, 16'h00FF, 1'b1, 7'h09, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h09, 16'h0000};
        vec[12] = '{1'b1, 7'h0A, 16'h4444, 16'h00FF, 1'b1, 7'h09, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00, 7'h0A, 16'h4444};
        vec[13] = '{1'b1, 7'h07, 16'h5555, 16'hFF00, 1'b1, 7'h0A, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h0A, 16'h0000};
        vec[14] = '{1'b1, 7'h07, 16'h5555, 16'hFF00, 1'b1, 7'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF, 7'h07, 16'h5555};
        vec[15] = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 7'h00, 16'h0000};
        vec[16] = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b1, 7'h07, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h07, 16'h0000};
        vec[17] = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b1, 7'h09, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h09, 16'h0000};
        vec[18] = '{1'b1, 7'h0B, 16'h0F0F, 16'hFFFF, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'h0B, 16'h0F0F};
        vec[19] = '{1'b1, 7'h0B, 16'h00F0, 16'hFFFF, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'h0B, 16'h00F0};
        vec[20] = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b1, 7'h0B, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 7'h0B, 16'h0000};
        vec[21] = '{1'b0, 7'h00, 16'h0000, 16'h0000, 1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 7'h00, 16'h0000};

        // Reset state, with both requesters pushing.
        #2;
        rst_n = 1'b0;
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        chk("rst_outs", {init_busy, wr_gnt, rd_gnt, rd_vld, rd_data, sram_cen, sram_gwen, sram_addr, sram_din},
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 7'h0, 16'h0});
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hold", {init_busy, wr_gnt, rd_gnt, sram_addr}, {1'b1, 1'b0, 1'b0, 7'h0});

        // Release: full sweep, then every entry reads back as zero.
        @(negedge clk);
        rst_n = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1;
        sweep(N + 50, 1'b0, n);
        chk("sweep_len", n, N);
        readback_all();

        // Vector table: masked writes, reads, arbitration order.
        for (int k = 0; k < 22; k++) begin
            step(vec[k].wr, vec[k].wa, vec[k].wd, vec[k].wm, vec[k].rd, vec[k].ra, 1'b0);
            chk($sformatf("vec%0d_gnt", k), {wr_gnt, rd_gnt}, {vec[k].wg, vec[k].rg});
            chk($sformatf("vec%0d_ctl", k), {sram_cen, sram_gwen, sram_wen, sram_addr},
                {vec[k].cen, vec[k].gwen, vec[k].wen, vec[k].addr});
            if (vec[k].wg || vec[k].cen) chk($sformatf("vec%0d_din", k), sram_din, vec[k].din);
            if (k == 3) chk("merge_a534", rd_data, 16'hA534);
            if (k == 4) chk("rd_hold", rd_data, 16'hA534);
        end

        // init_req right after a read grant; requesters held during sweep.
        step(0, '0, '0, '0, 1, 7'h05, 0);
        chk("i44_rg", rd_gnt, 1);
        step(1, 7'h10, 16'hFFFF, 16'hFFFF, 1, 7'h11, 1);
        chk("i44_blk", {wr_gnt, rd_gnt, init_busy, rd_vld, rd_data}, {1'b0, 1'b0, 1'b0, 1'b1, 16'hA534});
        @(negedge clk);
        init_req = 1'b0;
        #1;
        sweep(N + 50, 1'b1, n);
        chk("i44_len", n, N);
        readback_all();

        // Reset while a read is in flight.
        step(1, 7'h03, 16'hBEEF, 16'hFFFF, 0, '0, 0);
        step(0, '0, '0, '0, 1, 7'h03, 0);
        step(0, '0, '0, '0, 0, '0, 0);
        step(0, '0, '0, '0, 1, 7'h03, 0);
        chk("hold_beef", rd_data, 16'hBEEF);
        @(negedge clk);
        rd_req = 1'b0;
        #1;
        chk("vld_pending", rd_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd", {rd_vld, rd_data, init_busy, sram_addr, wr_gnt, rd_gnt},
            {1'b0, 16'h0, 1'b1, 7'h0, 1'b0, 1'b0});
        exp_q.delete();

        // Reset again at sweep address 60; sweep restarts from 0.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sweep(60, 1'b0, n);
        chk("part_len", n, 60);
        chk("at60", sram_addr, 60);
        rst_n = 1'b0;
        #1;
        chk("rst60", {init_busy, sram_addr, sram_cen}, {1'b1, 7'h0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        sweep(N + 50, 1'b0, n);
        chk("rst60_len", n, N);

        // Pointer favours read after reset; old data is gone.
        step(1, 7'h20, 16'h0001, 16'hFFFF, 1, 7'h03, 0);
        chk("rr_rst", {wr_gnt, rd_gnt}, 2'b01);
        step(1, 7'h20, 16'h0001, 16'hFFFF, 0, '0, 0);
        chk("rr_wr", wr_gnt, 1);
        step(0, '0, '0, '0, 1, 7'h20, 0);
        step(0, '0, '0, '0, 0, '0, 0);
        chk("q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
